// File: rtl/cnn_acc_ci_seq.sv
// Sequential channel-accumulating convolution: one KXxKY window per cycle, ox fastest, then oy, then ich.
// Define CNN_ACC_RELU_EN to clamp negative output elements to zero when the result is loaded.
module cnn_acc_ci_seq #(
    parameter int ICH      = 3,
    parameter int IX       = 7,
    parameter int IY       = 4,
    parameter int KX       = 3,
    parameter int KY       = 3,
    parameter int DATA_LEN = 8,
    parameter int ACC_LEN  = 16
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        i_soft_reset,
    input  logic [ICH*KX*KY*DATA_LEN-1:0]               i_cnn_weight,
    input  logic [ICH*IX*IY*DATA_LEN-1:0]               i_in_fmap,
    input  logic                                        i_in_valid,
    output logic                                        o_in_ready,
    output logic                                        o_ot_valid,
    input  logic                                        i_ot_ready,
    output logic [(IX-KX+1)*(IY-KY+1)*ACC_LEN-1:0]      o_ot_ci_acc,
    output logic                                        o_busy
);

    localparam int OX   = IX - KX + 1;
    localparam int OY   = IY - KY + 1;
    localparam int NPIX = OX * OY;
    localparam int OXW  = (OX > 1) ? $clog2(OX) : 1;
    localparam int OYW  = (OY > 1) ? $clog2(OY) : 1;
    localparam int ICW  = (ICH > 1) ? $clog2(ICH) : 1;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_reg, state_next;

    logic [ICH*KX*KY*DATA_LEN-1:0] w_reg;
    logic [ICH*IX*IY*DATA_LEN-1:0] fmap_reg;
    logic [OXW-1:0]                ox_reg;
    logic [OYW-1:0]                oy_reg;
    logic [ICW-1:0]                ich_reg;

    logic                          run_en;
    logic                          accept;
    logic                          last_win;

    logic signed [2*DATA_LEN-1:0]  prod;
    logic signed [ACC_LEN-1:0]     win_sum;
    int                            fidx;
    int                            widx;

    logic signed [ACC_LEN-1:0]     sum_reg;
    logic [PW-1:0]                 pix_reg;
    logic                          first_reg;
    logic                          last_reg;
    logic                          sum_vld_reg;
    logic                          ot_valid_reg;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else if (i_soft_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_in_valid)                  state_next = RUN;
            RUN:     if (last_win)                    state_next = DONE;
            DONE:    if (ot_valid_reg && i_ot_ready)  state_next = IDLE;
            default:                                  state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_in_ready = (state_reg == IDLE);
        o_busy     = (state_reg == RUN);
        run_en     = (state_reg == RUN);
    end

    assign accept     = i_in_valid && o_in_ready;
    assign last_win   = run_en && (ox_reg == OXW'(OX - 1)) && (oy_reg == OYW'(OY - 1))
                        && (ich_reg == ICW'(ICH - 1));
    assign o_ot_valid = ot_valid_reg;

    // Job operands are snapshotted so upstream may change them freely after the handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            w_reg    <= i_cnn_weight;
            fmap_reg <= i_in_fmap;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ox_reg  <= '0;
            oy_reg  <= '0;
            ich_reg <= '0;
        end else if (i_soft_reset) begin
            ox_reg  <= '0;
            oy_reg  <= '0;
            ich_reg <= '0;
        end else if (run_en) begin
            if (ox_reg == OXW'(OX - 1)) begin
                ox_reg <= '0;
                if (oy_reg == OYW'(OY - 1)) begin
                    oy_reg <= '0;
                    if (ich_reg == ICW'(ICH - 1)) ich_reg <= '0;
                    else                          ich_reg <= ich_reg + ICW'(1);
                end else begin
                    oy_reg <= oy_reg + OYW'(1);
                end
            end else begin
                ox_reg <= ox_reg + OXW'(1);
            end
        end
    end

    // Full-width products, sign-extended and summed modulo 2^ACC_LEN.
    always_comb begin
        win_sum = '0;
        prod    = '0;
        fidx    = 0;
        widx    = 0;
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
                fidx    = (int'(ich_reg) * IY + int'(oy_reg) + ky) * IX + int'(ox_reg) + kx;
                widx    = (int'(ich_reg) * KY + ky) * KX + kx;
                prod    = $signed(fmap_reg[fidx*DATA_LEN +: DATA_LEN])
                        * $signed(w_reg[widx*DATA_LEN +: DATA_LEN]);
                win_sum = win_sum + ACC_LEN'(prod);
            end
        end
    end

    // The window sum is registered before accumulation, which puts one cycle between
    // the last RUN cycle and the result appearing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_reg     <= '0;
            pix_reg     <= '0;
            first_reg   <= 1'b0;
            last_reg    <= 1'b0;
            sum_vld_reg <= 1'b0;
        end else if (i_soft_reset) begin
            sum_reg     <= '0;
            pix_reg     <= '0;
            first_reg   <= 1'b0;
            last_reg    <= 1'b0;
            sum_vld_reg <= 1'b0;
        end else begin
            sum_reg     <= win_sum;
            pix_reg     <= PW'(int'(oy_reg) * OX + int'(ox_reg));
            first_reg   <= (ich_reg == '0);
            last_reg    <= last_win;
            sum_vld_reg <= run_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ot_valid_reg <= 1'b0;
        end else if (i_soft_reset) begin
            ot_valid_reg <= 1'b0;
        end else if (sum_vld_reg && last_reg) begin
            ot_valid_reg <= 1'b1;
        end else if (ot_valid_reg && i_ot_ready) begin
            ot_valid_reg <= 1'b0;
        end
    end

    // One accumulator and one output register per output pixel.
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_pix
        logic signed [ACC_LEN-1:0] acc_reg;
        logic signed [ACC_LEN-1:0] acc_next;
        logic signed [ACC_LEN-1:0] out_next;
        logic signed [ACC_LEN-1:0] out_reg;

        assign acc_next = (sum_vld_reg && (pix_reg == PW'(gi)))
                        ? (first_reg ? sum_reg : acc_reg + sum_reg)
                        : acc_reg;
`ifdef CNN_ACC_RELU_EN
        assign out_next = acc_next[ACC_LEN-1] ? '0 : acc_next;
`else
        assign out_next = acc_next;
`endif

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc_reg <= '0;
                out_reg <= '0;
            end else if (i_soft_reset) begin
                acc_reg <= '0;
                out_reg <= '0;
            end else begin
                acc_reg <= acc_next;
                if (sum_vld_reg && last_reg) out_reg <= out_next;
            end
        end

        assign o_ot_ci_acc[gi*ACC_LEN +: ACC_LEN] = out_reg;
    end

endmodule

// File: tb/tb_cnn_acc_ci_seq.sv
// Bench for cnn_acc_ci_seq at default parameters: uniform-pattern table, stall, soft/async reset, random jobs.
// Honours CNN_ACC_RELU_EN in its expected values.
module tb_cnn_acc_ci_seq;

    localparam int ICH = 3, IX = 7, IY = 4, KX = 3, KY = 3, DL = 8, AL = 16;
    localparam int OX = IX - KX + 1, OY = IY - KY + 1, NPIX = OX * OY, N = ICH * NPIX;
    localparam int WW = ICH * KX * KY * DL, FW = ICH * IX * IY * DL, OW = NPIX * AL;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_soft_reset = 1'b0;
    logic [WW-1:0] i_cnn_weight = '0;
    logic [FW-1:0] i_in_fmap = '0;
    logic          i_in_valid = 1'b0;
    logic          o_in_ready;
    logic          o_ot_valid;
    logic          i_ot_ready = 1'b0;
    logic [OW-1:0] o_ot_ci_acc;
    logic          o_busy;

    cnn_acc_ci_seq dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_soft_reset (i_soft_reset),
        .i_cnn_weight (i_cnn_weight),
        .i_in_fmap    (i_in_fmap),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .o_ot_valid   (o_ot_valid),
        .i_ot_ready   (i_ot_ready),
        .o_ot_ci_acc  (o_ot_ci_acc),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    logic [OW-1:0] sb[$];

    typedef struct {
        logic signed [7:0] fval;
        logic signed [7:0] wval;
        logic [15:0]       exp_elem;
        int                stall;
        string             name;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic fail_to(input string name);
        n_total++;
        $display("FAIL %s: bound expired without the event, required event within bound", name);
    endtask

    function automatic logic [FW-1:0] fill_f(input logic [7:0] v);
        logic [FW-1:0] r;
        for (int i = 0; i < ICH * IX * IY; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [WW-1:0] fill_w(input logic [7:0] v);
        logic [WW-1:0] r;
        for (int i = 0; i < ICH * KX * KY; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [OW-1:0] rep_o(input logic [15:0] v);
        logic [OW-1:0] r;
        for (int i = 0; i < NPIX; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    // Reference convolution straight from the port layout description.
    function automatic logic [OW-1:0] model(input logic [FW-1:0] f, input logic [WW-1:0] w);
        logic [OW-1:0]       r;
        logic signed [15:0]  acc;
        logic signed [7:0]   a;
        logic signed [7:0]   b;
        logic signed [15:0]  p;
        r = '0;
        for (int oy = 0; oy < OY; oy++) begin
            for (int ox = 0; ox < OX; ox++) begin
                acc = '0;
                for (int c = 0; c < ICH; c++) begin
                    for (int ky = 0; ky < KY; ky++) begin
                        for (int kx = 0; kx < KX; kx++) begin
                            a   = f[(c*IX*IY + (oy+ky)*IX + (ox+kx))*8 +: 8];
                            b   = w[(c*KX*KY + ky*KX + kx)*8 +: 8];
                            p   = a * b;
                            acc = acc + p;
                        end
                    end
                end
`ifdef CNN_ACC_RELU_EN
                if (acc < 0) acc = '0;
`endif
                r[(oy*OX + ox)*16 +: 16] = acc;
            end
        end
        return r;
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < FW / 32; i++) i_in_fmap[i*32 +: 32] = $urandom();
        for (int i = 0; i < WW / 8; i++) i_cnn_weight[i*8 +: 8] = 8'($urandom());
    endtask

    // Offers a job, waits for acceptance, pushes the expected result; returns just after the accept edge.
    task automatic send_job(input logic [FW-1:0] f, input logic [WW-1:0] w, output int acc_cyc);
        int n;
        i_in_fmap    = f;
        i_cnn_weight = w;
        i_in_valid   = 1'b1;
        n = 0;
        acc_cyc = -1;
        @(negedge clk);
        while (!o_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!o_in_ready) begin
            fail_to("accept");
            i_in_valid = 1'b0;
            return;
        end
        sb.push_back(model(f, w));
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        i_in_valid = 1'b0;
        scramble_inputs();
    endtask

    // Waits for the result, stalls while poking inputs, then takes it and checks against the scoreboard.
    task automatic wait_result(input int acc_cyc, input int stall, output int lat, output int busy_cnt,
                               output int hs_cyc, output logic [OW-1:0] res);
        int n;
        logic [OW-1:0] hold;
        lat = -1; busy_cnt = 0; hs_cyc = -1; res = '0; n = 0;
        i_ot_ready = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
            if (o_ot_valid) break;
            n++;
        end
        if (!o_ot_valid) begin
            fail_to("result_valid");
            return;
        end
        lat  = cyc - acc_cyc;
        hold = o_ot_ci_acc;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            i_in_valid = 1'($urandom_range(0, 1));
            scramble_inputs();
            @(negedge clk);
            chk("stall_hold", {o_ot_valid, o_in_ready, o_ot_ci_acc}, {1'b1, 1'b0, hold});
        end
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        i_ot_ready = 1'b1;
        @(negedge clk);
        res = o_ot_ci_acc;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard: result %0h with no pending job, required none", o_ot_ci_acc);
        end else begin
            chk("scoreboard", o_ot_ci_acc, sb.pop_front());
        end
        chk("ready_low_at_hs", o_in_ready, 1'b0);
        @(posedge clk);
        #1;
        hs_cyc     = cyc;
        i_ot_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, required finish before 300000 ns");
        $fatal(1);
    end

    initial begin
        int a, lat, bc, hs, prev_hs, seen;
        logic [OW-1:0] res;

        tbl[0] = '{8'sd1,    8'sd1,   16'd27,   0,  "ones"};
`ifdef CNN_ACC_RELU_EN
        tbl[1] = '{8'sd1,    -8'sd1,  16'h0000, 3,  "neg_w"};
        tbl[2] = '{8'sd2,    -8'sd3,  16'h0000, 0,  "neg_small"};
`else
        tbl[1] = '{8'sd1,    -8'sd1,  16'hFFE5, 3,  "neg_w"};
        tbl[2] = '{8'sd2,    -8'sd3,  16'hFF5E, 0,  "neg_small"};
`endif
        tbl[3] = '{-8'sd128, 8'sd127, 16'h4D80, 1,  "min_fmap"};
        tbl[4] = '{8'sd127,  8'sd127, 16'hA51B, 10, "max_wrap"};

        // Reset state
        @(negedge clk);
        chk("reset_outs", {o_ot_valid, o_busy, o_ot_ci_acc}, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", {o_in_ready, o_busy, o_ot_valid}, 3'b100);
        @(posedge clk);
        #1;

        // Uniform-pattern table, jobs offered back to back
        prev_hs = -1;
        for (int i = 0; i < 5; i++) begin
            send_job(fill_f(tbl[i].fval), fill_w(tbl[i].wval), a);
            if (a < 0) continue;
            if (i > 0) chk_int("hs_to_accept_gap", a - prev_hs, 1);
            wait_result(a, tbl[i].stall, lat, bc, hs, res);
            chk_int("latency", lat, N + 1);
            chk_int("busy_cycles", bc, N);
            chk({"table_", tbl[i].name}, res, rep_o(tbl[i].exp_elem));
            $display("job %s: latency %0d busy %0d out %0h", tbl[i].name, lat, bc, res);
            prev_hs = hs;
        end

        // Soft reset in the middle of RUN aborts the job
        send_job(fill_f(8'd1), fill_w(8'd2), a);
        repeat (11) @(posedge clk);
        #1;
        chk("busy_before_soft", o_busy, 1'b1);
        i_soft_reset = 1'b1;
        @(posedge clk);
        #1;
        i_soft_reset = 1'b0;
        @(negedge clk);
        chk("soft_reset_state", {o_busy, o_in_ready, o_ot_valid}, 3'b010);
        chk("soft_reset_out", o_ot_ci_acc, '0);
        if (sb.size() > 0) void'(sb.pop_back());
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_ot_valid || o_busy) seen++;
        end
        chk_int("no_activity_after_abort", seen, 0);
        @(posedge clk);
        #1;

        // Soft reset wins over a same-cycle input handshake
        i_in_valid   = 1'b1;
        i_soft_reset = 1'b1;
        @(posedge clk);
        #1;
        i_in_valid   = 1'b0;
        i_soft_reset = 1'b0;
        @(negedge clk);
        chk("soft_beats_accept", {o_busy, o_in_ready}, 2'b01);
        @(posedge clk);
        #1;

        // Job after the abort, then random jobs
        send_job(fill_f(8'd1), fill_w(8'd2), a);
        if (a >= 0) begin
            wait_result(a, 0, lat, bc, hs, res);
            chk("after_soft_job", res, rep_o(16'd54));
        end
        for (int j = 0; j < 3; j++) begin
            logic [FW-1:0] rf;
            logic [WW-1:0] rw;
            for (int i = 0; i < FW / 32; i++) rf[i*32 +: 32] = $urandom();
            for (int i = 0; i < WW / 8; i++) rw[i*8 +: 8] = 8'($urandom());
            send_job(rf, rw, a);
            if (a < 0) continue;
            wait_result(a, $urandom_range(0, 3), lat, bc, hs, res);
            chk_int("rand_latency", lat, N + 1);
            $display("job random%0d: latency %0d out %0h", j, lat, res);
        end

        // Asynchronous reset during RUN
        send_job(fill_f(8'd3), fill_w(8'd1), a);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {o_busy, o_ot_valid, o_ot_ci_acc}, '0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("async_release", {o_in_ready, o_busy, o_ot_valid}, 3'b100);

        chk_int("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cnn_acc_ci_seq.md
CNN_ACC_CI_SEQ -- requirements
Module: cnn_acc_ci_seq

Interface
REQ-001 Parameter ICH, default 3: number of input channels, ≥1.
REQ-002 Parameter IX, default 7: input fmap width.
REQ-003 Parameter IY, default 4: input fmap height.
REQ-004 Parameter KX, default 3: kernel width, ≤IX.
REQ-005 Parameter KY, default 3: kernel height, ≤IY.
REQ-006 Parameter DATA_LEN, default 8: signed fmap and weight element width.
REQ-007 Parameter ACC_LEN, default 16: signed accumulator and output element width, ≥2*DATA_LEN.
REQ-008 Derived localparams: OX=IX-KX+1, OY=IY-KY+1, N=ICH*OX*OY.
REQ-009 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-010 Port reset_n, input, 1: asynchronous active-low reset.
REQ-011 Port i_soft_reset, input, 1: synchronous clear, active high.
REQ-012 Port i_cnn_weight, input, ICH*KX*KY*DATA_LEN: weights. Channel c kernel is at [c*KX*KY*DATA_LEN +: KX*KY*DATA_LEN]. Element (ky,kx) is at (ky*KX+kx)*DATA_LEN.
REQ-013 Port i_in_fmap, input, ICH*IX*IY*DATA_LEN: fmaps. Channel c is at [c*IX*IY*DATA_LEN +: IX*IY*DATA_LEN]. Element (y,x) is at (y*IX+x)*DATA_LEN.
REQ-014 Port i_in_valid, input, 1: input job offered.
REQ-015 Port o_in_ready, output, 1: block can accept a job.
REQ-016 Port o_ot_valid, output, 1: result valid, held until accepted.
REQ-017 Port i_ot_ready, input, 1: downstream accepts the result.
REQ-018 Port o_ot_ci_acc, output, OX*OY*ACC_LEN: result. Pixel (oy,ox) is at (oy*OX+ox)*ACC_LEN.
REQ-019 Port o_busy, output, 1: high in RUN.

Function
REQ-020 FSM states SHALL be IDLE, RUN and DONE.
- IDLE→RUN on i_in_valid&o_in_ready.
- RUN→DONE after the last window.
- DONE→IDLE on o_ot_valid&i_ot_ready.
REQ-021 o_in_ready SHALL be 1 only in IDLE; i_in_valid in RUN or DONE is ignored.
REQ-022 On accept, i_cnn_weight and i_in_fmap SHALL be registered; input changes after that do not affect the job.
REQ-023 RUN SHALL process one window per cycle using counters ox, oy, ich (ox fastest, then oy, then ich), all starting at 0.
REQ-024 Window sum SHALL be the sum over ky,kx of signed fmap[ich][oy+ky][ox+kx]*weight[ich][ky][kx]. Products are full 2*DATA_LEN width and are sign-extended to ACC_LEN.
REQ-025 Accumulator update for acc[oy*OX+ox]:
- ich==0: acc <= window sum.
- otherwise: acc <= acc + window sum, wrapping modulo 2^ACC_LEN.
REQ-026 RUN SHALL last exactly N cycles. The last window is ich=ICH-1, oy=OY-1, ox=OX-1; the counters then return to 0.
REQ-027 Accepting a job at edge T SHALL give RUN on cycles T+1..T+N, with o_ot_valid rising at edge T+N+1.
REQ-028 o_ot_ci_acc SHALL be registered, change only on entry to DONE, and stay stable while o_ot_valid=1.
REQ-029 In DONE, o_ot_valid SHALL stay 1 until i_ot_ready=1, for any stall length.
REQ-030 A new job SHALL NOT be accepted in the same cycle the result is accepted; o_in_ready rises the next cycle.
REQ-031 ICH=1, OX=1 or OY=1 SHALL be legal; N=1 gives a single RUN cycle.

Reset
REQ-032 When reset_n=0, asynchronously:
- state=IDLE and counters=0;
- accumulators and o_ot_ci_acc = 0;
- o_ot_valid=0, o_busy=0, o_in_ready=1 once reset is released.
REQ-033 i_soft_reset=1 at an edge SHALL apply the same values as REQ-032 synchronously, in any state; a RUN job in progress is aborted with no output.
REQ-034 i_soft_reset SHALL take priority over a same-cycle input or output handshake.

Configuration
REQ-035 Macro CNN_ACC_RELU_EN controls a ReLU stage on the output.
- Defined: on entry to DONE, each o_ot_ci_acc element that is negative is replaced by 0.
- Undefined: the accumulator value is passed through unchanged.
- Latency is identical in both cases.

Verification
REQ-036 Defaults, all fmap=1, all weights=1, accept at T → o_ot_valid rises at T+31; every element = 27.
REQ-037 Defaults, fmap=1, weights=-1 → every element -27 (0xFFE5); with CNN_ACC_RELU_EN → every element 0.
REQ-038 Hold i_ot_ready=0 for 10 cycles in DONE while toggling i_in_valid and inputs → o_ot_valid and o_ot_ci_acc stable, o_in_ready=0.
REQ-039 Pulse i_soft_reset at RUN cycle 12 → next cycle IDLE, o_ot_valid=0, output 0; a following job gives the correct result.
REQ-040 Defaults with DATA_LEN=8, fmap=127, weights=127 → every element 27*16129=435483, wrapped to 16 bits = 0xA51B; repeated back-to-back jobs show exactly one idle cycle between the output handshake and the next o_in_ready.
